jam_eval_ctrl: RTL and testbench



---
 rtl/jam_pkg.sv | 46 ++++
 rtl/jam_min_tracker.sv | 65 ++++++
 rtl/jam_eval_ctrl.sv | 176 +++++++++++++++++
 tb/tb_jam_eval_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// jam_pkg: shared constants, state encoding and small helpers for the
// 8-worker / 8-job assignment evaluation datapath.
//   N_WORK   workers (and jobs) per permutation
//   COST_W   width of one cost-table entry
//   SUM_W    width of an accumulated permutation total
//   CNT_W    width of the saturating match counter
//   K_W      width of a worker/job index
//   SUM_INIT start value of the running minimum (above any reachable sum)
package jam_pkg;

  localparam int N_WORK = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;
  localparam int K_W    = 3;
  localparam int PERM_W = N_WORK * K_W;

  localparam logic [SUM_W-1:0] SUM_INIT = 10'h3FF;
  localparam logic [CNT_W-1:0] CNT_MAX  = 4'hF;
  localparam logic [K_W-1:0]   K_LAST   = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PERM = 3'd1,
    FETCH     = 3'd2,
    DRAIN     = 3'd3,
    CMP       = 3'd4,
    DONE      = 3'd5
  } jam_state_e;

  // Job assigned to worker k inside a packed permutation.
  function automatic logic [K_W-1:0] perm_job(input logic [PERM_W-1:0] perm,
                                              input logic [K_W-1:0]    k);
    perm_job = perm[int'(k) * K_W +: K_W];
  endfunction

  // Increment that sticks at the counter maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_MAX) begin
      sat_inc = c;
    end else begin
      sat_inc = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/jam_min_tracker.sv
// jam_min_tracker: running-minimum tracker with a saturating tie counter.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   init         reload minimum to SUM_INIT and clear the count
//   cmp_en       score 'sum' against the current minimum this cycle
//   sum          candidate total
//   min_cost     smallest total seen since the last init
//   match_count  number of candidates equal to min_cost (saturates at 15)
module jam_min_tracker
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             init,
  input  logic             cmp_en,
  input  logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] min_cost,
  output logic [CNT_W-1:0] match_count
);

  logic [SUM_W-1:0] min_cost_r;
  logic [CNT_W-1:0] cnt_r;
  logic [SUM_W-1:0] min_nx_s;
  logic [CNT_W-1:0] cnt_nx_s;

  // Next minimum/count: init wins, then a strictly smaller sum restarts the
  // count at one, an equal sum extends it.
  always_comb begin
    min_nx_s = min_cost_r;
    cnt_nx_s = cnt_r;
    if (init) begin
      min_nx_s = SUM_INIT;
      cnt_nx_s = {CNT_W{1'b0}};
    end else if (cmp_en) begin
      if (sum < min_cost_r) begin
        min_nx_s = sum;
        cnt_nx_s = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (sum == min_cost_r) begin
        min_nx_s = min_cost_r;
        cnt_nx_s = sat_inc(cnt_r);
      end else begin
        min_nx_s = min_cost_r;
        cnt_nx_s = cnt_r;
      end
    end else begin
      min_nx_s = min_cost_r;
      cnt_nx_s = cnt_r;
    end
  end

  // Minimum and count registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      min_cost_r <= SUM_INIT;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      min_cost_r <= min_nx_s;
      cnt_r      <= cnt_nx_s;
    end
  end

  assign min_cost    = min_cost_r;
  assign match_count = cnt_r;

endmodule

// File: rtl/jam_eval_ctrl.sv
// jam_eval_ctrl: scores permutations of the 8x8 assignment problem.
// Each accepted permutation is costed by eight cost-table reads (W = worker,
// J = assigned job), the costs are summed, and the sum is folded into the
// running minimum / tie count. The round ends after the permutation flagged
// with perm_last; results are then held with Valid until the next start.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   start                         one-cycle pulse, begins a round (IDLE/DONE only)
//   perm_valid/perm_ready         permutation handshake
//   perm_data[23:0]               job of worker k in bits [3k+2:3k]
//   perm_last                     marks the final permutation of the round
//   rd_en, W, J                   cost-table read request
//   Cost                          read data, one cycle after rd_en
//   MinCost, MatchCount, Valid    round result
//   busy                          round in progress
module jam_eval_ctrl
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              perm_valid,
  output logic              perm_ready,
  input  logic [PERM_W-1:0] perm_data,
  input  logic              perm_last,
  output logic              rd_en,
  output logic [K_W-1:0]    W,
  output logic [K_W-1:0]    J,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid,
  output logic              busy
);

  jam_state_e        state_r, state_nx_s;
  logic [K_W-1:0]    k_r, k_nx_s;
  logic [PERM_W-1:0] perm_r, perm_nx_s;
  logic              last_r, last_nx_s;
  logic [SUM_W-1:0]  acc_r, acc_nx_s;
  logic              valid_r, valid_nx_s;
  logic              perm_ready_r;
  logic              rd_en_r;
  logic              rd_dly_r;
  logic [K_W-1:0]    w_r;
  logic [K_W-1:0]    j_r;
  logic              busy_r;
  logic              init_s;
  logic              cmp_en_s;

  // Next state, datapath updates and tracker strobes.
  always_comb begin
    state_nx_s = state_r;
    k_nx_s     = k_r;
    perm_nx_s  = perm_r;
    last_nx_s  = last_r;
    valid_nx_s = valid_r;
    init_s     = 1'b0;
    cmp_en_s   = 1'b0;
    // Cost returns one cycle after its read, so the add follows the delayed
    // strobe; this is what makes DRAIN pick up the k = 7 entry.
    if (rd_dly_r) begin
      acc_nx_s = acc_r + {{(SUM_W-COST_W){1'b0}}, Cost};
    end else begin
      acc_nx_s = acc_r;
    end

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nx_s = WAIT_PERM;
          init_s     = 1'b1;
          valid_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end
      WAIT_PERM: begin
        if (perm_valid && perm_ready_r) begin
          state_nx_s = FETCH;
          perm_nx_s  = perm_data;
          last_nx_s  = perm_last;
          acc_nx_s   = {SUM_W{1'b0}};
          k_nx_s     = {K_W{1'b0}};
        end else begin
          state_nx_s = WAIT_PERM;
        end
      end
      FETCH: begin
        k_nx_s = k_r + {{(K_W-1){1'b0}}, 1'b1};
        if (k_r == K_LAST) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = FETCH;
        end
      end
      DRAIN: begin
        state_nx_s = CMP;
      end
      CMP: begin
        cmp_en_s = 1'b1;
        if (last_r) begin
          state_nx_s = DONE;
          valid_nx_s = 1'b1;
        end else begin
          state_nx_s = WAIT_PERM;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      k_r      <= {K_W{1'b0}};
      perm_r   <= {PERM_W{1'b0}};
      last_r   <= 1'b0;
      acc_r    <= {SUM_W{1'b0}};
      valid_r  <= 1'b0;
      rd_dly_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      k_r      <= k_nx_s;
      perm_r   <= perm_nx_s;
      last_r   <= last_nx_s;
      acc_r    <= acc_nx_s;
      valid_r  <= valid_nx_s;
      rd_dly_r <= rd_en_r;
    end
  end

  // Outputs registered from the next state so each matches the state it
  // belongs to without a decode stage after the flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perm_ready_r <= 1'b0;
      rd_en_r      <= 1'b0;
      w_r          <= {K_W{1'b0}};
      j_r          <= {K_W{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      perm_ready_r <= (state_nx_s == WAIT_PERM);
      rd_en_r      <= (state_nx_s == FETCH);
      busy_r       <= (state_nx_s != IDLE) && (state_nx_s != DONE);
      if (state_nx_s == FETCH) begin
        w_r <= k_nx_s;
        j_r <= perm_job(perm_nx_s, k_nx_s);
      end else begin
        w_r <= {K_W{1'b0}};
        j_r <= {K_W{1'b0}};
      end
    end
  end

  jam_min_tracker u_min_tracker (
    .CLK         (CLK),
    .RST         (RST),
    .init        (init_s),
    .cmp_en      (cmp_en_s),
    .sum         (acc_r),
    .min_cost    (MinCost),
    .match_count (MatchCount)
  );

  assign perm_ready = perm_ready_r;
  assign rd_en      = rd_en_r;
  assign W          = w_r;
  assign J          = j_r;
  assign Valid      = valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_jam_eval_ctrl.sv
// tb_jam_eval_ctrl: self-checking bench for jam_eval_ctrl. A cost-table
// model answers reads one cycle after rd_en; round results are predicted
// from the table and the list of permutations sent.
module tb_jam_eval_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        perm_valid = 1'b0;
  logic        perm_ready;
  logic [23:0] perm_data = 24'd0;
  logic        perm_last = 1'b0;
  logic        rd_en;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost = 7'd0;
  logic [9:0]  MinCost;
  logic [3:0]  MatchCount;
  logic        Valid;
  logic        busy;

  jam_eval_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .perm_valid (perm_valid),
    .perm_ready (perm_ready),
    .perm_data  (perm_data),
    .perm_last  (perm_last),
    .rd_en      (rd_en),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [6:0]  tbl [8][8];
  logic [23:0] plist[$];
  logic [5:0]  rd_q[$];
  int          rd_cyc_q[$];
  int          acc_cyc_q[$];
  int          rdy_cnt = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cost-table model and transaction monitor.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      Cost <= tbl[W][J];
      rd_q.push_back({W, J});
      rd_cyc_q.push_back(cyc);
    end
    if (perm_valid && perm_ready) acc_cyc_q.push_back(cyc);
    if (perm_ready) rdy_cnt <= rdy_cnt + 1;
  end

  function automatic int perm_cost(input logic [23:0] p);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'(tbl[k][p[3*k +: 3]]);
    return s;
  endfunction

  function automatic logic [23:0] rand_perm(input bit any);
    int a[8];
    logic [23:0] p;
    for (int i = 0; i < 8; i++) a[i] = i;
    for (int i = 7; i > 0; i--) begin
      int r = $urandom_range(0, i);
      int t = a[i];
      a[i] = a[r];
      a[r] = t;
    end
    for (int k = 0; k < 8; k++) begin
      if (any) p[3*k +: 3] = 3'($urandom_range(0, 7));
      else     p[3*k +: 3] = 3'(a[k]);
    end
    return p;
  endfunction

  task automatic fill_const(input int v);
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w][j] = 7'(v);
  endtask

  task automatic fill_rand();
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w][j] = 7'($urandom_range(0, 127));
  endtask

  // Called at a negedge; leaves at the negedge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_perm(input string tag, input logic [23:0] p, input logic last, input bit keep);
    int n = 0;
    perm_valid = 1'b1;
    perm_data  = p;
    perm_last  = last;
    while (!perm_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("%s_ready_wait", tag), 64'(n < 100), 64'd1);
    @(negedge CLK);
    if (!keep) perm_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!Valid && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("%s_valid", tag), 64'(Valid), 64'd1);
  endtask

  // One full round over plist; optionally holds perm_valid high and/or
  // pulses start while the permutation at index disturb_at is fetched.
  task automatic run_round(input string tag, input bit held, input int disturb_at);
    int sums[$];
    int best;
    int cnt;
    int n = plist.size();
    pulse_start();
    rd_q.delete();
    rd_cyc_q.delete();
    acc_cyc_q.delete();
    rdy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      send_perm(tag, plist[i], 1'(i == n - 1), held && (i != n - 1));
      if (i == disturb_at) begin
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk($sformatf("%s_busy_after_start", tag), 64'(busy), 64'd1);
      end
    end
    wait_valid(tag);

    best = 1023;
    foreach (plist[i]) begin
      sums.push_back(perm_cost(plist[i]));
      if (sums[i] < best) best = sums[i];
    end
    cnt = 0;
    foreach (sums[i]) if (sums[i] == best) cnt++;
    if (cnt > 15) cnt = 15;
    chk($sformatf("%s_min", tag), 64'(MinCost), 64'(best));
    chk($sformatf("%s_cnt", tag), 64'(MatchCount), 64'(cnt));
    chk($sformatf("%s_busy_done", tag), 64'(busy), 64'd0);
    chk($sformatf("%s_rd_count", tag), 64'(rd_q.size()), 64'(8 * n));

    for (int i = 0; i < n; i++) begin
      logic [47:0] got = 48'd0;
      logic [47:0] exp = 48'd0;
      if (rd_q.size() >= 8 * (i + 1)) begin
        for (int k = 0; k < 8; k++) begin
          logic [2:0] kk = 3'(k);
          got = {got[41:0], rd_q[8*i + k]};
          exp = {exp[41:0], kk, plist[i][3*k +: 3]};
        end
        chk($sformatf("%s_wj_p%0d", tag, i), 64'(got), 64'(exp));
        chk($sformatf("%s_consec_p%0d", tag, i),
            64'(rd_cyc_q[8*i + 7] - rd_cyc_q[8*i]), 64'd7);
      end
    end
  endtask

  initial begin
    logic [23:0] p;

    // Reset state and idle perm_valid ignored.
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_min", 64'(MinCost), 64'h3FF);
    chk("rst_cnt", 64'(MatchCount), 64'd0);
    chk("rst_valid", 64'(Valid), 64'd0);
    chk("rst_ready", 64'(perm_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wj", 64'({rd_en, W, J}), 64'd0);
    perm_valid = 1'b1;
    perm_data  = 24'hFAC688;
    repeat (3) @(negedge CLK);
    perm_valid = 1'b0;
    @(negedge CLK);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_reads", 64'(rd_q.size()), 64'd0);

    // Single permutation {7,6,...,0}, all costs 5.
    fill_const(5);
    for (int k = 0; k < 8; k++) p[3*k +: 3] = 3'(7 - k);
    plist = '{p};
    run_round("single", 1'b0, -1);
    chk("single_min40", 64'(MinCost), 64'd40);
    chk("single_cnt1", 64'(MatchCount), 64'd1);

    // Ties: W+J table with worker-0 offsets giving totals 100, 90, 90.
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) tbl[w][j] = 7'(w + j);
    tbl[0][0] = 7'(0 + 44);
    tbl[0][1] = 7'(1 + 34);
    tbl[0][2] = 7'(2 + 34);
    plist.delete();
    plist.push_back(24'o76543210);
    plist.push_back(24'o76543201);
    plist.push_back(24'o76543102);
    run_round("tie", 1'b0, -1);
    chk("tie_min90", 64'(MinCost), 64'd90);
    chk("tie_cnt2", 64'(MatchCount), 64'd2);

    // Maximum costs, counter saturation, then restart clears the result.
    fill_const(127);
    plist.delete();
    for (int i = 0; i < 20; i++) plist.push_back(rand_perm(1'b0));
    run_round("max", 1'b1, -1);
    chk("max_min1016", 64'(MinCost), 64'd1016);
    chk("max_cnt15", 64'(MatchCount), 64'd15);
    pulse_start();
    chk("restart_valid", 64'(Valid), 64'd0);
    chk("restart_cnt", 64'(MatchCount), 64'd0);
    chk("restart_min", 64'(MinCost), 64'h3FF);
    send_perm("restart", 24'o01234567, 1'b1, 1'b0);
    wait_valid("restart");
    chk("restart_end_min", 64'(MinCost), 64'd1016);

    // Handshake timing with perm_valid held high across four permutations.
    fill_rand();
    plist.delete();
    for (int i = 0; i < 4; i++) plist.push_back(rand_perm(1'b0));
    run_round("held", 1'b1, -1);
    chk("held_accepts", 64'(acc_cyc_q.size()), 64'd4);
    chk("held_ready_cycles", 64'(rdy_cnt), 64'd4);
    for (int i = 1; i < acc_cyc_q.size(); i++)
      chk($sformatf("held_gap%0d", i), 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd11);

    // start during FETCH is ignored.
    fill_rand();
    plist.delete();
    for (int i = 0; i < 3; i++) plist.push_back(rand_perm(1'b0));
    run_round("fetch_start", 1'b0, 1);

    // RST at FETCH k = 4: outputs return to reset values immediately.
    fill_rand();
    pulse_start();
    send_perm("midrst", rand_perm(1'b0), 1'b1, 1'b0);
    begin
      int n = 0;
      while (!(rd_en && W == 3'd4) && n < 50) begin
        @(negedge CLK);
        n++;
      end
      chk("midrst_reach_k4", 64'({rd_en, W}), 64'({1'b1, 3'd4}));
    end
    RST = 1'b1;
    #1;
    chk("midrst_ready", 64'(perm_ready), 64'd0);
    chk("midrst_rd", 64'({rd_en, W, J}), 64'd0);
    chk("midrst_min", 64'(MinCost), 64'h3FF);
    chk("midrst_cnt", 64'(MatchCount), 64'd0);
    chk("midrst_valid_busy", 64'({Valid, busy}), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    plist.delete();
    for (int i = 0; i < 2; i++) plist.push_back(rand_perm(1'b0));
    run_round("after_rst", 1'b0, -1);

    // Randomized rounds, including arbitrary job indices and repeats.
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 5);
      fill_rand();
      plist.delete();
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 2) == 0) plist.push_back(plist[i-1]);
        else plist.push_back(rand_perm(1'($urandom_range(0, 1))));
      end
      run_round($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
